fetch_stage: RTL

Instruction-fetch stage of the five-stage pipelined CPU. It is the producer side of the IF/ID interface: it owns the fetch PC and drives a request/response instruction-memory port. It holds the IF/ID pipeline register that feeds the decode stage's `instruction`/`pc_4` inputs. It consumes decode's `shouldStall` and branch redirect, and implements MIPS delayed branches with one delay slot.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding
// request/response instruction memory port and holds the IF/ID register.
// Delayed branches with one delay slot: the slot after a branch is always
// fetched, and the redirect either retargets the fetch PC directly or is
// parked until the delay-slot request has been issued.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_REQUEST | request valid on imemAddress, waiting for imemReady
// S_WAIT    | request accepted, waiting for imemResponseValid
// S_FULL    | response captured in buffer while decode stalls
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic        imemResponseValid,
  input  logic [31:0] imemResponseData,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic [31:0] instruction,
  output logic [31:0] pc_4,
  output logic        instructionValid,
  output logic [31:0] debug_fetchPc
);

  typedef enum logic [1:0] {
    S_REQUEST = 2'd0,
    S_WAIT    = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_imem_request;
  logic [31:0] r_fetch_pc;
  logic        r_pending_redirect;
  logic [31:0] r_pending_target;
  logic [31:0] r_out_pc4;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic        w_id_advance;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_unused;

  // Decode handshake, word-aligned redirect target and the wrapping PC adder.
  assign w_id_advance = !shouldStall;
  assign w_redirect   = r_ifid_valid && shouldJumpOrBranch && w_id_advance;
  assign w_target     = {jumpOrBranchPc[31:2], 2'b00};
  assign w_pc_plus4   = r_fetch_pc + 32'd4;
  assign w_unused     = &{1'b0, jumpOrBranchPc[1:0]};

  assign imemRequest      = r_imem_request;
  assign imemAddress      = r_fetch_pc;
  assign instruction      = r_ifid_instr;
  assign pc_4             = r_ifid_pc4;
  assign instructionValid = r_ifid_valid;
  assign debug_fetchPc    = r_fetch_pc;

  // Fetch FSM, PC/redirect bookkeeping, response buffer and IF/ID register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state            <= S_REQUEST;
      r_imem_request     <= 1'b1;
      r_fetch_pc         <= RESET_PC;
      r_pending_redirect <= 1'b0;
      r_pending_target   <= 32'd0;
      r_out_pc4          <= 32'd0;
      r_buf_data         <= 32'd0;
      r_buf_pc4          <= 32'd0;
      r_ifid_instr       <= 32'd0;
      r_ifid_pc4         <= 32'd0;
      r_ifid_valid       <= 1'b0;
    end else begin
      // An advancing decode takes a bubble unless an instruction is delivered below.
      if (w_id_advance) begin
        r_ifid_valid <= 1'b0;
        r_ifid_instr <= 32'd0;
        r_ifid_pc4   <= 32'd0;
      end

      case (r_state)
        S_REQUEST: begin
          if (imemReady) begin
            r_out_pc4          <= w_pc_plus4;
            r_fetch_pc         <= r_pending_redirect ? r_pending_target : w_pc_plus4;
            r_pending_redirect <= 1'b0;
            r_state            <= S_WAIT;
            r_imem_request     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imemResponseValid) begin
            if (w_id_advance) begin
              r_ifid_valid   <= 1'b1;
              r_ifid_instr   <= imemResponseData;
              r_ifid_pc4     <= r_out_pc4;
              r_state        <= S_REQUEST;
              r_imem_request <= 1'b1;
            end else begin
              r_buf_data <= imemResponseData;
              r_buf_pc4  <= r_out_pc4;
              r_state    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          // Responses arriving here are protocol violations and are ignored.
          if (w_id_advance) begin
            r_ifid_valid   <= 1'b1;
            r_ifid_instr   <= r_buf_data;
            r_ifid_pc4     <= r_buf_pc4;
            r_state        <= S_REQUEST;
            r_imem_request <= 1'b1;
          end
        end
        default: begin
          r_state        <= S_REQUEST;
          r_imem_request <= 1'b1;
        end
      endcase

      // The delay slot is always fetched: park the target if its request has
      // not been accepted yet, otherwise retarget the fetch PC right away.
      if (w_redirect) begin
        if ((r_state == S_REQUEST) && !imemReady) begin
          r_pending_redirect <= 1'b1;
          r_pending_target   <= w_target;
        end else begin
          r_fetch_pc <= w_target;
        end
      end
    end
  end

endmodule
